// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: sized loads/stores into local data memory with multi-cycle stall.
// Optional MEM_MISALIGN_TRAP_EN: misaligned memory ops commit at once, flagged and without side effects.
module mem_access_stage #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DEPTH          = 1024,
    parameter int MEM_LATENCY    = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      inValid,
    input  logic                      inRegWrite,
    input  logic [4:0]                inDestReg,
    input  logic [BUS_DATA_WIDTH-1:0] inResult,
    input  logic [BUS_DATA_WIDTH-1:0] writeData,
    input  logic                      inMemOrReg,
    input  logic                      inMemRead,
    input  logic                      inMemWrite,
    input  logic [1:0]                inSize,
    input  logic                      inUnsigned,
    input  logic                      inBranch,
    input  logic                      inZero,
    input  logic [BUS_DATA_WIDTH-1:0] inBta,
    output logic                      stall,
    output logic                      outValid,
    output logic [BUS_DATA_WIDTH-1:0] readData,
    output logic [BUS_DATA_WIDTH-1:0] outResult,
    output logic [4:0]                outDestReg,
    output logic                      outMemOrReg,
    output logic                      outRegWrite,
    output logic                      outPcSrc,
    output logic [BUS_DATA_WIDTH-1:0] outBta,
    output logic                      outMisalign
);
    localparam int BYTES = BUS_DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int BIT_W = $clog2(BUS_DATA_WIDTH);
    localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);
    localparam logic [BUS_DATA_WIDTH-1:0] ONES = '1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, stateNext;
    logic [3:0] cnt, cntNext;
    logic commit;

    logic [BUS_DATA_WIDTH-1:0] mem [DEPTH];

    logic [OFF_W-1:0] off, sizeMask, alignedOff;
    logic [IDX_W-1:0] wordIdx;
    logic [1:0]       effSize;
    logic             memOp, isStore, isLoad, trap;
    logic [BYTES-1:0] byteEn;
    logic [BUS_DATA_WIDTH-1:0] storeData, loadWord, loadMask, loadExt;
    logic [BIT_W-1:0] signIdx;
    logic             unusedAddrBits;

    assign off            = inResult[OFF_W-1:0];
    assign wordIdx        = inResult[OFF_W +: IDX_W];
    assign unusedAddrBits = ^inResult[BUS_DATA_WIDTH-1:OFF_W+IDX_W];

    // A dword request on a 32-bit bus degrades to a word access.
    assign effSize    = (BUS_DATA_WIDTH == 32 && inSize == 2'd3) ? 2'd2 : inSize;
    assign sizeMask   = OFF_W'((4'd1 << effSize) - 4'd1);
    assign alignedOff = off & ~sizeMask;

    assign memOp   = inValid & (inMemRead | inMemWrite);
    assign isStore = memOp & inMemWrite;
    assign isLoad  = memOp & inMemRead & ~inMemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = memOp & (|(off & sizeMask));
`else
    assign trap = 1'b0;
    assign outMisalign = 1'b0;
`endif

    always_comb begin
        byteEn = '0;
        for (int b = 0; b < BYTES; b++)
            byteEn[b] = (b >= int'(alignedOff)) && (b < int'(alignedOff) + (1 << effSize));
    end

    assign storeData = writeData << {alignedOff, 3'b000};
    assign loadWord  = mem[wordIdx] >> {alignedOff, 3'b000};

    // A full-width mask leaves nothing above the sign bit, so full-width loads ignore inUnsigned.
    always_comb begin
        loadMask = ONES >> (BUS_DATA_WIDTH - (8 << effSize));
        signIdx  = BIT_W'((8 << effSize) - 1);
        loadExt  = loadWord & loadMask;
        if (!inUnsigned && loadWord[signIdx])
            loadExt = loadExt | ~loadMask;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        stall     = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (memOp && !trap && MEM_LATENCY > 1) begin
                    stateNext = BUSY;
                    cntNext   = 4'd1;
                    stall     = 1'b1;
                end else begin
                    commit = inValid;
                end
            end
            BUSY: begin
                if (cnt == LAST) begin
                    stateNext = IDLE;
                    cntNext   = 4'd0;
                    commit    = 1'b1;
                end else begin
                    cntNext = cnt + 4'd1;
                    stall   = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            outValid    <= 1'b0;
            outRegWrite <= 1'b0;
            outMemOrReg <= 1'b0;
            outDestReg  <= 5'd0;
            outResult   <= '0;
            readData    <= '0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            outValid <= commit;
            if (commit) begin
                outResult   <= inResult;
                outDestReg  <= inDestReg;
                outMemOrReg <= inMemOrReg;
                outRegWrite <= inRegWrite & ~trap;
                if (isLoad && !trap)
                    readData <= loadExt;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            outMisalign <= 1'b0;
        else
            outMisalign <= commit & trap;
    end
`endif

    // NOTE: the memory array has no reset; gating with reset_n aborts a store pending under reset.
    always_ff @(posedge clk) begin
        if (reset_n && commit && isStore && !trap) begin
            for (int b = 0; b < BYTES; b++)
                if (byteEn[b])
                    mem[wordIdx][8*b +: 8] <= storeData[8*b +: 8];
        end
    end

    assign outPcSrc = inValid & inBranch & inZero;
    assign outBta   = inBta;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Fourth pipeline stage (memory access) for the in-order RISC core, between the EX stage and write-back. Performs sized, sign/zero-extending loads and byte-masked stores into a parametrised local data memory with configurable access latency and a stall handshake toward upstream stages. Registers the write-back controls, and resolves taken branches combinationally toward the IF-stage PC mux.

## Interface
Parameters:
- BUS_DATA_WIDTH, 64, data/word width in bits; 32 or 64.
- DEPTH, 1024, memory words; power of two.
- MEM_LATENCY, 1, cycles per memory access; 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- inValid  in  1  upstream instruction valid.
- inRegWrite  in  1  instruction writes the register file.
- inDestReg  in  5  destination register number.
- inResult  in  BUS_DATA_WIDTH  ALU result; this is the byte address for memory ops.
- writeData  in  BUS_DATA_WIDTH  store data, right-aligned.
- inMemOrReg  in  1  1 = write back the ALU result; 0 = write back load data.
- inMemRead, inMemWrite  in  1 each  load / store request.
- inSize  in  2  access size: 0 byte, 1 half, 2 word, 3 dword. 3 is illegal when BUS_DATA_WIDTH=32 and is treated as 2.
- inUnsigned  in  1  zero-extend the load when 1; sign-extend when 0.
- inBranch, inZero  in  1 each  branch instruction / ALU zero flag.
- inBta  in  BUS_DATA_WIDTH  branch target address.
- stall  out  1  upstream must hold all inputs while high.
- outValid  out  1  write-back outputs are valid.
- readData  out  BUS_DATA_WIDTH  extended load data.
- outResult  out  BUS_DATA_WIDTH  registered ALU result.
- outDestReg  out  5; outMemOrReg, outRegWrite  out  1 each  registered controls.
- outPcSrc  out  1  take the branch.
- outBta  out  BUS_DATA_WIDTH  equals inBta.
- outMisalign  out  1  misaligned access flag. Driven only when the macro is enabled; tied 0 otherwise.

## Operation
- Address split:
  - OFF = inResult[log2(BUS_DATA_WIDTH/8)-1:0].
  - Word index = the next log2(DEPTH) bits. Higher bits are ignored, so addresses wrap modulo DEPTH words.
- A memory op is one with inValid & (inMemRead | inMemWrite).
  - If both read and write are set, the op is a store and the load is ignored.
- Store: writes only bytes OFF .. OFF+2^inSize-1 from the low bytes of writeData. Other bytes are preserved.
- Load: extracts 2^inSize bytes at OFF, then zero- or sign-extends per inUnsigned. A dword load on 64-bit ignores inUnsigned.
- Misaligned access (OFF not a multiple of 2^inSize), without the macro: OFF is aligned down to the size.
- FSM states IDLE and BUSY, with a 4-bit counter CNT.
  - IDLE, memory op, MEM_LATENCY>1: go to BUSY with CNT=1.
  - BUSY, CNT==MEM_LATENCY-1: go to IDLE. The access commits on this edge.
  - BUSY otherwise: CNT increments.
  - IDLE with a non-memory op, or MEM_LATENCY==1: the access commits on the edge, with no stall.
- stall = (IDLE & memory op & MEM_LATENCY>1) | (BUSY & CNT != MEM_LATENCY-1). Combinational.
- On commit: all out* registers load, outValid=1, and readData is updated for loads. readData holds its previous value for non-loads.
- On a non-commit edge: outValid=0. Other out* registers hold.
- outPcSrc = inValid & inBranch & inZero, combinational. outBta = inBta.
- Reset (asynchronous):
  - State goes to IDLE, CNT=0, outValid=0, outRegWrite=0, outMemOrReg=0, outDestReg=0, outResult=0, readData=0, outMisalign=0.
  - A pending store is aborted and memory is not written.
  - Memory contents are not reset.

## Timing
- Non-memory op accepted in cycle N: outputs are valid in cycle N+1.
- Memory op accepted in cycle N: stall is high in cycles N..N+L-2, low in N+L-1. Outputs are valid in cycle N+L, where L = MEM_LATENCY.
- Back-to-back ops are accepted every cycle when L=1, and every L cycles otherwise.
- Load data is visible in cycle N+L, which is where write-back consumes it.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned memory op commits in one cycle with no stall.
  - It suppresses the memory write and forces outRegWrite=0.
  - It sets outMisalign=1 alongside outValid for that one cycle.
- Undefined: misaligned accesses align down as described under Operation, and outMisalign is constant 0.

## Test plan
- Reset asserted mid-BUSY (L=3) during a store of 0xDEAD to word 5 -> all outputs read 0, and a later load of word 5 returns its prior value.
- L=1: dword store 0x1122334455667788 to address 0x40, then a byte load of 0x43 signed -> readData=0x0000000000000055. Half load of 0x46 -> 0x1122.
- Byte store 0xFF to 0x41, then signed byte load of 0x41 -> 0xFFFFFFFFFFFFFFFF. Unsigned -> 0xFF. Dword load of 0x40 -> 0x112233445566FF88.
- L=4: load accepted in cycle 10 -> stall high in cycles 10-12, low in 13, outValid=1 only in cycle 14. An ALU op in cycle 14 gives outValid in cycle 15.
- inBranch=1, inZero=1, inValid=1, inBta=0x2000 -> outPcSrc=1 in the same cycle, outBta=0x2000. With inValid=0 -> outPcSrc=0.
- With MEM_MISALIGN_TRAP_EN, half store to 0x43 -> outMisalign=1 and outRegWrite=0 for one cycle, memory unchanged. Without the macro, the same store writes bytes 0x42-0x43.
